// File: rtl/pea_pkg.sv
// Shared PE-array definitions: default array geometry, the partial-sum word type
// and the serializer state encoding used by the OFM collector.
package pea_pkg;

    localparam int PEA_COL       = 8;
    localparam int PEA_OFM_WIDTH = 32;

    typedef logic signed [PEA_OFM_WIDTH-1:0] sum_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_EMIT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/ofm_row_fifo.sv
// Capture storage for the OFM collector: a DEPTH-entry circular buffer of whole
// result rows with first-word-fall-through read and simultaneous push/pop when full.
module ofm_row_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full buffer only lands when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && !clear_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ofm_collector.sv
// Output-feature-map collector: captures masked PE-array result rows and serialises their
// valid lanes into a tile-framed word stream. Optional build macro: OFM_COLLECTOR_RELU_EN.
module ofm_collector
    import pea_pkg::*;
#(
    parameter int  COL       = PEA_COL,
    parameter int  OFM_WIDTH = $bits(sum_t),
    parameter int  DEPTH     = 4,
    localparam int CW        = $clog2(COL),
    localparam int EW        = COL + COL * OFM_WIDTH,
    localparam int NW        = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [15:0]                   tile_words,
    input  logic [COL-1:0]                sum_valid,
    input  logic [COL-1:0][OFM_WIDTH-1:0] sum,
    output logic                          ofm_valid,
    input  logic                          ofm_ready,
    output logic [OFM_WIDTH-1:0]          ofm_data,
    output logic [CW-1:0]                 ofm_col,
    output logic                          ofm_last,
    output logic                          afull,
    output logic                          overflow,
    output ser_state_e                    dbg_state
);

    // Handshake: a word transfers on each rising edge with ofm_valid && ofm_ready high (and
    // clear low); once raised, ofm_valid and the word hold until that transfer, clear or rst.

    logic [EW-1:0]                 fifo_rdata;
    logic                          fifo_full, fifo_empty;
    logic [NW-1:0]                 fifo_count;
    logic [COL-1:0]                head_mask;
    logic [COL-1:0][OFM_WIDTH-1:0] head_sum;

    logic [COL-1:0]       done_q, done_d;
    logic [COL-1:0]       pending, cur_onehot, rest;
    logic [CW-1:0]        cur_col;
    logic                 lane_last;
    logic [OFM_WIDTH-1:0] lane_raw, lane_word;

    logic accept, pop, capture, push_ok, drop;

    ser_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, tile_q, tile_cur;
    logic [16:0] tile_ext;
    logic        word_last;
    logic        afull_q, afull_d, overflow_q, overflow_d;
    logic [NW-1:0] count_nxt;

    ofm_row_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i ({sum, sum_valid}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_mask = fifo_rdata[COL-1:0];
    assign head_sum  = fifo_rdata[EW-1:COL];

    // done_q marks lanes of the head row already handed downstream; the lowest remaining one is next.
    always_comb begin
        pending = head_mask & ~done_q;
        cur_col = '0;
        for (int i = COL - 1; i >= 0; i--) begin
            if (pending[i]) begin
                cur_col = CW'(i);
            end
        end
        cur_onehot          = '0;
        cur_onehot[cur_col] = 1'b1;
        rest                = pending & ~cur_onehot;
        lane_last           = (rest == '0);
        lane_raw            = head_sum[cur_col];
    end

`ifdef OFM_COLLECTOR_RELU_EN
    assign lane_word = lane_raw[OFM_WIDTH-1] ? '0 : lane_raw;
`else
    assign lane_word = lane_raw;
`endif

    assign accept  = ofm_valid && ofm_ready && !clear;
    assign pop     = accept && lane_last;
    assign capture = (|sum_valid) && !clear;
    assign push_ok = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    // Serializer FSM: state register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    state_d = SER_EMIT;
                end
            end
            SER_EMIT: begin
                if (pop && !push_ok && (fifo_count == NW'(1))) begin
                    state_d = SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Serializer FSM: outputs
    always_comb begin
        ofm_valid = (state_q == SER_EMIT);
        ofm_data  = ofm_valid ? lane_word : '0;
        ofm_col   = ofm_valid ? cur_col : '0;
        ofm_last  = ofm_valid && word_last;
    end

    assign dbg_state = state_q;

    // Tile length is taken live while the counter sits at 0 and frozen for the rest of the tile.
    always_comb begin
        tile_cur  = (cnt_q == '0) ? tile_words : tile_q;
        tile_ext  = (tile_cur == '0) ? 17'h10000 : {1'b0, tile_cur};
        word_last = ({1'b0, cnt_q} == (tile_ext - 17'd1));
        cnt_d     = cnt_q;
        done_d    = done_q;
        if (accept) begin
            cnt_d  = word_last ? '0 : cnt_q + 16'd1;
            done_d = lane_last ? '0 : (done_q | cur_onehot);
        end
        count_nxt  = fifo_count + NW'(push_ok) - NW'(pop);
        afull_d    = (count_nxt >= NW'(DEPTH - 1));
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q      <= '0;
            tile_q     <= '0;
            done_q     <= '0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tile_q     <= tile_cur;
            done_q     <= done_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    assign afull    = afull_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ofm_collector.sv
// Self-checking bench for ofm_collector: directed scenarios plus randomized traffic,
// scored against a row/word-level reference model through an expected-word queue.
module tb_ofm_collector;
    import pea_pkg::*;

    localparam int COL   = 8;
    localparam int OW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int EW    = OW + CW + 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   clear = 1'b0;
    logic [15:0]            tile_words = '0;
    logic [COL-1:0]         sum_valid = '0;
    logic [COL-1:0][OW-1:0] sum = '0;
    logic                   ofm_ready = 1'b0;
    logic                   ofm_valid;
    logic [OW-1:0]          ofm_data;
    logic [CW-1:0]          ofm_col;
    logic                   ofm_last;
    logic                   afull;
    logic                   overflow;
    ser_state_e             dbg_state;

    int tests = 0;
    int fails = 0;

    // Expected words {last, col, data} in emission order, and words left per buffered row.
    logic [EW-1:0] exp_q[$];
    int            row_left[$];
    int            m_cnt   = 0;
    int            m_tile  = 65536;
    logic          m_afull = 1'b0;
    logic          m_ovf   = 1'b0;
    int            m_words;
    logic          m_last;

    ofm_collector #(
        .COL       (COL),
        .OFM_WIDTH (OW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .tile_words (tile_words),
        .sum_valid  (sum_valid),
        .sum        (sum),
        .ofm_valid  (ofm_valid),
        .ofm_ready  (ofm_ready),
        .ofm_data   (ofm_data),
        .ofm_col    (ofm_col),
        .ofm_last   (ofm_last),
        .afull      (afull),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] relu_model(input logic [OW-1:0] v);
`ifdef OFM_COLLECTOR_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // ---------------- reference model (row level) ----------------
    always @(posedge clk) begin
        if (rst || clear) begin
            exp_q.delete();
            row_left.delete();
            m_cnt   = 0;
            m_afull = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (ofm_valid && ofm_ready && row_left.size() > 0) begin
                row_left[0] = row_left[0] - 1;
                if (row_left[0] == 0) begin
                    void'(row_left.pop_front());
                end
            end
            if (|sum_valid) begin
                if (row_left.size() < DEPTH) begin
                    m_words = 0;
                    for (int i = 0; i < COL; i++) begin
                        if (sum_valid[i]) begin
                            if (m_cnt == 0) begin
                                m_tile = (tile_words == 16'd0) ? 65536 : int'(tile_words);
                            end
                            m_last = (m_cnt == m_tile - 1);
                            exp_q.push_back({m_last, CW'(i), relu_model(sum[i])});
                            m_cnt   = m_last ? 0 : m_cnt + 1;
                            m_words = m_words + 1;
                        end
                    end
                    row_left.push_back(m_words);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_afull = (row_left.size() >= DEPTH - 1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (afull !== m_afull) begin
                fails++;
                $display("FAIL afull_track @%0t: got %0b expected %0b", $time, afull, m_afull);
            end
            tests++;
            if (overflow !== m_ovf) begin
                fails++;
                $display("FAIL overflow_track @%0t: got %0b expected %0b", $time, overflow, m_ovf);
            end
            if (ofm_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word @%0t: got col %0d data %0h last %0b, none expected",
                             $time, ofm_col, ofm_data, ofm_last);
                end else if ({ofm_last, ofm_col, ofm_data} !== exp_q[0]) begin
                    fails++;
                    $display("FAIL word @%0t: got last %0b col %0d data %0h expected last %0b col %0d data %0h",
                             $time, ofm_last, ofm_col, ofm_data,
                             exp_q[0][EW-1], exp_q[0][EW-2:OW], exp_q[0][OW-1:0]);
                end
                if (ofm_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_sum();
        for (int i = 0; i < COL; i++) begin
            sum[i] = $urandom;
        end
    endtask

    task automatic drive(input logic [COL-1:0] m);
        sum_valid = m;
        tick();
        sum_valid = '0;
    endtask

    task automatic do_clear(input logic [15:0] t);
        clear      = 1'b1;
        tile_words = t;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k         = 0;
        ofm_ready = 1'b1;
        sum_valid = '0;
        while ((exp_q.size() != 0 || ofm_valid) && k < budget) begin
            tick();
            k++;
        end
        tests++;
        if (exp_q.size() != 0 || ofm_valid) begin
            fails++;
            $display("FAIL drain: %0d words still expected after %0d cycles", exp_q.size(), budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) tick();
        check("rst_valid", 64'(ofm_valid), 64'd0);
        check("rst_data", 64'(ofm_data), 64'd0);
        check("rst_col", 64'(ofm_col), 64'd0);
        check("rst_last", 64'(ofm_last), 64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick();

        // Full row 1..8, latency and back-to-back words
        ofm_ready = 1'b1;
        for (int i = 0; i < COL; i++) begin
            sum[i] = OW'(i + 1);
        end
        drive(8'hFF);
        check("lat_not_yet", 64'(ofm_valid), 64'd0);
        tick();
        check("lat_valid", 64'(ofm_valid), 64'd1);
        check("lat_col0", 64'(ofm_col), 64'd0);
        check("lat_data1", 64'(ofm_data), 64'd1);
        drain(20);

        // Stride mask
        rand_sum();
        drive(8'h55);
        drain(20);

        // Stall mid-row
        do_clear(16'd0);
        ofm_ready = 1'b1;
        rand_sum();
        drive(8'hFF);
        tick();
        ofm_ready = 1'b0;
        repeat (5) tick();
        drain(20);

        // Fill and overflow with downstream blocked
        ofm_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            rand_sum();
            drive(8'hFF);
            if (n == 2) check("afull_at2", 64'(afull), 64'd0);
            if (n == 3) check("afull_at3", 64'(afull), 64'd1);
            if (n == 4) check("ovf_at4", 64'(overflow), 64'd0);
            if (n == 5) check("ovf_at5", 64'(overflow), 64'd1);
        end
        drain(60);

        // Tile framing with 6-word tiles
        do_clear(16'd6);
        ofm_ready = 1'b1;
        rand_sum();
        drive(8'hFF);
        rand_sum();
        drive(8'hFF);
        drain(40);

        // Clear with rows buffered
        ofm_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            rand_sum();
            drive(8'hFF);
        end
        check("pre_clear_afull", 64'(afull), 64'd1);
        do_clear(16'd0);
        check("clr_valid", 64'(ofm_valid), 64'd0);
        check("clr_afull", 64'(afull), 64'd0);
        check("clr_overflow", 64'(overflow), 64'd0);

        // Reset with rows buffered and overflow set
        for (int n = 0; n < 5; n++) begin
            rand_sum();
            drive(8'hF0);
        end
        check("pre_rst_overflow", 64'(overflow), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_valid", 64'(ofm_valid), 64'd0);
        check("rstmid_afull", 64'(afull), 64'd0);
        check("rstmid_overflow", 64'(overflow), 64'd0);
        ofm_ready = 1'b1;
        rand_sum();
        drive(8'hFF);
        tick();
        check("after_rst_col0", 64'(ofm_col), 64'd0);
        drain(20);

        // Negative result through the optional rectifier
        do_clear(16'd0);
        ofm_ready = 1'b1;
        rand_sum();
        sum[0] = 32'hFFFF_FFFB;
        drive(8'h01);
        tick();
        check("relu_valid", 64'(ofm_valid), 64'd1);
`ifdef OFM_COLLECTOR_RELU_EN
        check("relu_data", 64'(ofm_data), 64'h0);
`else
        check("relu_data", 64'(ofm_data), 64'hFFFF_FFFB);
`endif
        drain(20);

        // Randomized traffic
        do_clear(16'd7);
        for (int c = 0; c < 800; c++) begin
            ofm_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                clear      = 1'b1;
                tile_words = 16'($urandom_range(0, 13));
            end else begin
                clear = 1'b0;
            end
            if ($urandom_range(0, 9) < 3) begin
                sum_valid = COL'($urandom_range(0, 255));
                rand_sum();
            end else begin
                sum_valid = '0;
            end
            tick();
        end
        clear = 1'b0;
        drain(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ofm_collector.md
OFM_COLLECTOR -- requirements
Module: ofm_collector

Interface
REQ-001 Parameter COL, default 8, number of PE-array output columns (even, >=2).
REQ-002 Parameter OFM_WIDTH, default 32, width of one partial-sum result word.
REQ-003 Parameter DEPTH, default 4, number of row entries in the capture FIFO (power of two, >=2).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous soft clear: empties FIFO, zeroes word counter, clears overflow.
REQ-007 tile_words  input  16  number of words per output tile; 0 means 65536; sampled when the word counter is 0.
REQ-008 sum_valid  input  COL  per-column result-valid mask from PE array (stride masking already applied).
REQ-009 sum  input  COL x OFM_WIDTH (sum_t array)  per-column results, qualified by sum_valid.
REQ-010 ofm_valid  output  1  output word available.
REQ-011 ofm_ready  input  1  downstream accepts word when high with ofm_valid.
REQ-012 ofm_data  output  OFM_WIDTH  output result word.
REQ-013 ofm_col  output  $clog2(COL)  source column index of ofm_data.
REQ-014 ofm_last  output  1  marks final word of a tile.
REQ-015 afull  output  1  FIFO occupancy >= DEPTH-1; controller stalls the array.
REQ-016 overflow  output  1  sticky: a capture was dropped.

Function
REQ-017 Capture: any cycle with |sum_valid writes one entry {sum_valid, sum[0..COL-1]} to the FIFO tail; an all-zero mask writes nothing.
REQ-018 Push into full FIFO is accepted only if the head entry's final lane is accepted in the same cycle; otherwise it is dropped and overflow sets.
REQ-019 Serializer emits the head entry's valid lanes in ascending column order, skipping invalid lanes, one word per accepted handshake.
REQ-020 Head entry pops in the same cycle its highest valid lane is accepted; the next entry's first lane is presented the following cycle (no bubble beyond that).
REQ-021 Latency: a capture into an empty FIFO at edge N drives ofm_valid high after edge N+1.
REQ-022 While ofm_valid=1 and ofm_ready=0, ofm_data, ofm_col and ofm_last hold stable and ofm_valid stays high.
REQ-023 Word counter increments per accepted word; ofm_last=1 when counter = tile_words-1; counter wraps to 0 on that acceptance.
REQ-024 Serializer FSM: IDLE (FIFO empty, ofm_valid=0) -> EMIT on non-empty; EMIT -> IDLE when last lane of last entry is accepted and no push in that cycle.
REQ-025 clear has priority over capture and handshake in the same cycle; ofm_valid=0 the cycle after.
REQ-026 afull and overflow are registered, updated on the edge the occupancy changes.

Reset
REQ-027 On rst: ofm_valid=0, ofm_data=0, ofm_col=0, ofm_last=0, afull=0, overflow=0, FIFO empty, word counter=0, FSM=IDLE.
REQ-028 rst mid-tile discards all buffered entries and in-flight words without emitting them.

Configuration
REQ-029 With OFM_COLLECTOR_RELU_EN defined, ofm_data = max(sum,0) (signed); without it, ofm_data is the signed sum unchanged.

Structure
REQ-030 sum_t, COL and OFM_WIDTH defaults live in shared package pea_pkg; the module imports them.
REQ-031 Capture storage is sub-module ofm_row_fifo (DEPTH x (COL + COL*OFM_WIDTH) bits, push/pop/full/empty/count).

Verification
REQ-032 Single capture sum_valid=8'hFF, sum[i]=i+1, ofm_ready=1 -> words 1..8 on 8 consecutive cycles, ofm_col 0..7, first valid after edge N+1.
REQ-033 Stride mask 8'h55 -> only cols 0,2,4,6 emitted, 4 words, entry pops after col 6.
REQ-034 ofm_ready held low 5 cycles mid-entry -> data/col/last stable; five captures fill DEPTH=4 -> afull=1 at 3, fifth dropped, overflow=1.
REQ-035 tile_words=6, two full-mask captures -> ofm_last on 6th word, counter wraps, 12th word also ofm_last.
REQ-036 rst or clear asserted with 3 entries buffered -> next cycle ofm_valid=0, afull=0, overflow=0; new capture emits col 0 first.
REQ-037 OFM_COLLECTOR_RELU_EN defined, sum=-5 -> ofm_data=0; undefined -> ofm_data=32'hFFFFFFFB.
